// File: rtl/sign_extender.sv
// Registered immediate-extension unit: widens an instruction immediate to the
// datapath width under a selectable extension mode, with a valid flag.
module sign_extender #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [2:0]           ext_mode,
    input  logic [IN_WIDTH-1:0]  numIn,
    output logic [OUT_WIDTH-1:0] numOut,
    output logic                 out_valid
);

    localparam int H = OUT_WIDTH - IN_WIDTH;

    localparam logic [2:0] MODE_SEXT      = 3'b000;
    localparam logic [2:0] MODE_ZEXT      = 3'b001;
    localparam logic [2:0] MODE_UPPER     = 3'b010;
    localparam logic [2:0] MODE_SEXT_BYTE = 3'b011;
    localparam logic [2:0] MODE_ZEXT_BYTE = 3'b100;
    localparam logic [2:0] MODE_BRANCH    = 3'b101;

    // Reserved encodings fall through to plain sign extension.
    function automatic logic signed [OUT_WIDTH-1:0] extend(
        input logic [2:0]          mode,
        input logic [IN_WIDTH-1:0] imm
    );
        logic signed [OUT_WIDTH-1:0] sext_w;
        logic signed [OUT_WIDTH-1:0] r;
        sext_w = {{H{imm[IN_WIDTH-1]}}, imm};
        case (mode)
            MODE_SEXT:      r = sext_w;
            MODE_ZEXT:      r = {{H{1'b0}}, imm};
            MODE_UPPER:     r = {imm, {H{1'b0}}};
            MODE_SEXT_BYTE: r = {{(OUT_WIDTH-8){imm[7]}}, imm[7:0]};
            MODE_ZEXT_BYTE: r = {{(OUT_WIDTH-8){1'b0}}, imm[7:0]};
            MODE_BRANCH:    r = sext_w <<< 2;
            default:        r = sext_w;
        endcase
        return r;
    endfunction

    logic signed [OUT_WIDTH-1:0] res_p0;
    logic signed [OUT_WIDTH-1:0] res_p1;
    logic                        vld_p1;

    // Stage 0: combinational extension
    always_comb begin
        res_p0 = extend(ext_mode, numIn);
    end

    // Stage 1: output register; captured regardless of in_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (en) begin
            res_p1 <= res_p0;
            vld_p1 <= in_valid;
        end
    end

    assign numOut    = res_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_sign_extender.sv
// Directed-vector bench for sign_extender: table of mode/value vectors plus
// hand-written reset, stall and valid-tracking sequences.
module tb_sign_extender;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [2:0]  ext_mode;
    logic [15:0] numIn;
    logic [31:0] numOut;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [2:0]  mode;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    sign_extender #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_valid (in_valid),
        .ext_mode (ext_mode),
        .numIn    (numIn),
        .numOut   (numOut),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{"sext_10",     3'b000, 16'd10,    32'h0000000A};
        vecs[1]  = '{"sext_2237",   3'b000, 16'd2237,  32'h000008BD};
        vecs[2]  = '{"sext_m24",    3'b000, 16'hFFE8,  32'hFFFFFFE8};
        vecs[3]  = '{"sext_m1234",  3'b000, 16'hFB2E,  32'hFFFFFB2E};
        vecs[4]  = '{"sext_max",    3'b000, 16'h7FFF,  32'h00007FFF};
        vecs[5]  = '{"sext_min",    3'b000, 16'h8000,  32'hFFFF8000};
        vecs[6]  = '{"zext",        3'b001, 16'h80F0,  32'h000080F0};
        vecs[7]  = '{"upper",       3'b010, 16'h80F0,  32'h80F00000};
        vecs[8]  = '{"sext_byte",   3'b011, 16'h80F0,  32'hFFFFFFF0};
        vecs[9]  = '{"zext_byte",   3'b100, 16'h80F0,  32'h000000F0};
        vecs[10] = '{"branch",      3'b101, 16'h80F0,  32'hFFFE03C0};
        vecs[11] = '{"mode111",     3'b111, 16'h80F0,  32'hFFFF80F0};
        vecs[12] = '{"mode110",     3'b110, 16'h0F70,  32'h00000F70};

        // Reset held for two edges with a valid input present
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; ext_mode = 3'b000; numIn = 16'h7FFF;
        step();
        check("rst_num_1", numOut, 32'h0);
        check("rst_vld_1", {31'b0, out_valid}, 32'h0);
        step();
        check("rst_num_2", numOut, 32'h0);
        check("rst_vld_2", {31'b0, out_valid}, 32'h0);
        rst_n = 1'b1;
        step();
        check("rel_vld", {31'b0, out_valid}, 32'h1);
        check("rel_num", numOut, 32'h00007FFF);

        // Table-driven vectors, one per cycle
        for (int i = 0; i < 13; i++) begin
            ext_mode = vecs[i].mode;
            numIn    = vecs[i].imm;
            in_valid = 1'b1;
            step();
            check(vecs[i].name, numOut, vecs[i].exp);
            check({vecs[i].name, "_vld"}, {31'b0, out_valid}, 32'h1);
        end

        // Stall: en low drops inputs and holds outputs
        ext_mode = 3'b000; numIn = 16'h0001; in_valid = 1'b1;
        step();
        check("stall_cap", numOut, 32'h00000001);
        en = 1'b0; numIn = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", numOut, 32'h00000001);
            check("stall_vld", {31'b0, out_valid}, 32'h1);
        end
        en = 1'b1;
        step();
        check("stall_resume", numOut, 32'hFFFFFFFF);

        // Valid tracking; data captured even when in_valid is low
        in_valid = 1'b1; numIn = 16'h0010;
        step();
        check("vt_vld1", {31'b0, out_valid}, 32'h1);
        check("vt_num1", numOut, 32'h00000010);
        in_valid = 1'b0; numIn = 16'h0020;
        step();
        check("vt_vld0", {31'b0, out_valid}, 32'h0);
        check("vt_num0", numOut, 32'h00000020);
        in_valid = 1'b1; numIn = 16'h0030;
        step();
        check("vt_vld2", {31'b0, out_valid}, 32'h1);
        check("vt_num2", numOut, 32'h00000030);

        // Reset pulse between edges only has no effect
        en = 1'b0; numIn = 16'h1234;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check("pulse_num", numOut, 32'h00000030);
        check("pulse_vld", {31'b0, out_valid}, 32'h1);

        // Reset across an edge overrides en low
        rst_n = 1'b0;
        step();
        check("rst_en0_num", numOut, 32'h0);
        check("rst_en0_vld", {31'b0, out_valid}, 32'h0);

        // First edge after release captures normally
        rst_n = 1'b1; en = 1'b1; in_valid = 1'b1; ext_mode = 3'b101; numIn = 16'h0001;
        step();
        check("post_rst_num", numOut, 32'h00000004);
        check("post_rst_vld", {31'b0, out_valid}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
